input_debounce_fsm: RTL and testbench

Conditions the raw, asynchronous push-button/switch input that drives the state machine's `x` input. It synchronizes the pin into the `clk` domain, samples it on a divided tick, and debounces it with a four-state FSM. It emits a clean level `x` plus single-cycle rise and fall strobes. It sits directly upstream of the JK-based state machine and replaces ad-hoc ripple-clock sampling with a single-clock, enable-based design.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/tick_gen.sv | 44 ++++
 rtl/input_debounce_fsm.sv | 153 +++++++++++++++
 tb/tb_input_debounce_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the push-button debouncer.
//   db_state_t : four-state debounce FSM encoding
//   level_of() : debounced level presented while in a given state
//   is_wait()  : true while a candidate level change is being qualified
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } db_state_t;

    // A WAIT state still reports the old, accepted level.
    function automatic logic level_of(input db_state_t s);
        return (s == HIGH) || (s == FALL_WAIT);
    endfunction

    function automatic logic is_wait(input db_state_t s);
        return (s == RISE_WAIT) || (s == FALL_WAIT);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle enable every DIV clk cycles.
// Used as a clock-enable instead of a derived slow clock.
//   clk   : system clock
//   reset : asynchronous, active-high; counter returns to 0
//   tick  : high on the last count of each period (combinational)
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap to zero after the last count of the period.
    always_comb begin
        count_d = count_q;
        if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    assign tick = (count_q == LAST);

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/input_debounce_fsm.sv
// ---------------------------------------------------------------------------
// input_debounce_fsm
// Synchronizes a raw button pin, samples it on a divided tick and debounces
// it with a four-state FSM.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   btn_in  : raw asynchronous pin (may bounce)
//   x       : debounced level (registered)
//   x_rise  : one-cycle pulse when x goes 0->1
//   x_fall  : one-cycle pulse when x goes 1->0
//   busy    : high while a candidate change is being qualified
// ---------------------------------------------------------------------------
module input_debounce_fsm
    import debounce_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic x,
    output logic x_rise,
    output logic x_fall,
    output logic busy
);

    localparam int QW = $clog2(STABLE_TICKS + 1);
    localparam logic [QW:0] ST_W = (QW + 1)'(STABLE_TICKS);
    localparam bit ST_ONE = (STABLE_TICKS == 1);

    logic       tick;
    logic       s1_q;
    logic       s2_q;
    db_state_t  state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [QW:0]   qcnt_inc;
    logic       qual_done;
    logic       x_q, x_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       busy_q, busy_d;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // One extra bit so the compare against STABLE_TICKS cannot wrap.
    assign qcnt_inc  = {1'b0, qcnt_q} + (QW + 1)'(1);
    assign qual_done = (qcnt_inc == ST_W);

    // FSM next-state, qualify counter and strobe decode; only ticks advance.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            case (state_q)
                LOW: begin
                    if (s2_q) begin
                        if (ST_ONE) begin
                            state_d = HIGH;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = RISE_WAIT;
                            qcnt_d  = QW'(1);
                        end
                    end else begin
                        state_d = LOW;
                    end
                end
                RISE_WAIT: begin
                    if (!s2_q) begin
                        state_d = LOW;
                        qcnt_d  = '0;
                    end else if (qual_done) begin
                        state_d = HIGH;
                        qcnt_d  = '0;
                        rise_d  = 1'b1;
                    end else begin
                        qcnt_d  = qcnt_inc[QW-1:0];
                    end
                end
                HIGH: begin
                    if (!s2_q) begin
                        if (ST_ONE) begin
                            state_d = LOW;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = FALL_WAIT;
                            qcnt_d  = QW'(1);
                        end
                    end else begin
                        state_d = HIGH;
                    end
                end
                FALL_WAIT: begin
                    if (s2_q) begin
                        state_d = HIGH;
                        qcnt_d  = '0;
                    end else if (qual_done) begin
                        state_d = LOW;
                        qcnt_d  = '0;
                        fall_d  = 1'b1;
                    end else begin
                        qcnt_d  = qcnt_inc[QW-1:0];
                    end
                end
                default: begin
                    state_d = LOW;
                    qcnt_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Outputs follow the next state so x changes on the accepting edge.
        x_d    = level_of(state_d);
        busy_d = is_wait(state_d);
    end

    // Synchronizer, FSM state, qualify counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= LOW;
            qcnt_q  <= '0;
            x_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            x_q     <= x_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign x      = x_q;
    assign x_rise = rise_q;
    assign x_fall = fall_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_input_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_input_debounce_fsm
// Three debouncer instances share clk/reset:
//   lane 0: TICK_DIV=1, STABLE_TICKS=3
//   lane 1: TICK_DIV=4, STABLE_TICKS=2
//   lane 2: TICK_DIV=1, STABLE_TICKS=1
// A behavioural model predicts every output each cycle; predictions are
// queued when the stimulus is driven and popped after the clock edge.
// Directed latency / pulse-count checks come straight from the timing rules.
// ---------------------------------------------------------------------------
module tb_input_debounce_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [2:0] x, xr, xf, busy;

    always #5 clk = ~clk;

    input_debounce_fsm #(.TICK_DIV(1), .STABLE_TICKS(3)) u_d3 (
        .clk(clk), .reset(reset), .btn_in(btn[0]),
        .x(x[0]), .x_rise(xr[0]), .x_fall(xf[0]), .busy(busy[0]));
    input_debounce_fsm #(.TICK_DIV(4), .STABLE_TICKS(2)) u_d4 (
        .clk(clk), .reset(reset), .btn_in(btn[1]),
        .x(x[1]), .x_rise(xr[1]), .x_fall(xf[1]), .busy(busy[1]));
    input_debounce_fsm #(.TICK_DIV(1), .STABLE_TICKS(1)) u_d1 (
        .clk(clk), .reset(reset), .btn_in(btn[2]),
        .x(x[2]), .x_rise(xr[2]), .x_fall(xf[2]), .busy(busy[2]));

    typedef struct {
        int   id;
        logic ex;
        logic er;
        logic ef;
        logic eb;
    } exp_t;

    exp_t sb[$];

    int td[3] = '{1, 4, 1};
    int st[3] = '{3, 2, 1};

    // Model: sync pipe, accepted level, count of consecutive differing ticks.
    logic m_s1[3], m_s2[3], m_x[3], m_r[3], m_f[3];
    int   m_c[3], m_cnt[3];

    int n_cmp = 0;
    int n_err = 0;

    // Segment bookkeeping (lane 0 / lane 2 event counters).
    int   rise_cnt0, fall_cnt0, busy_edges0, busy_cnt2;
    logic busy_prev0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_x[i] = 1'b0;
            m_r[i] = 1'b0;  m_f[i] = 1'b0;  m_c[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Advance the model by one clock edge and queue its predictions.
    task automatic model_edge();
        logic tk;
        for (int i = 0; i < 3; i++) begin
            tk = (m_cnt[i] == td[i] - 1);
            m_r[i] = 1'b0;
            m_f[i] = 1'b0;
            if (tk) begin
                if (m_s2[i] != m_x[i]) begin
                    m_c[i]++;
                    if (m_c[i] == st[i]) begin
                        m_x[i] = ~m_x[i];
                        m_r[i] = m_x[i];
                        m_f[i] = ~m_x[i];
                        m_c[i] = 0;
                    end
                end else begin
                    m_c[i] = 0;
                end
            end
            m_s2[i]  = m_s1[i];
            m_s1[i]  = btn[i];
            m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
            sb.push_back('{i, m_x[i], m_r[i], m_f[i], (m_c[i] > 0)});
        end
    endtask

    // Drive one cycle of stimulus, then score the DUT after the edge.
    task automatic step(input logic [2:0] b);
        exp_t e;
        btn = b;
        model_edge();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("x[%0d]", e.id), x[e.id], e.ex);
            check($sformatf("x_rise[%0d]", e.id), xr[e.id], e.er);
            check($sformatf("x_fall[%0d]", e.id), xf[e.id], e.ef);
            check($sformatf("busy[%0d]", e.id), busy[e.id], e.eb);
        end
        rise_cnt0 += int'(xr[0]);
        fall_cnt0 += int'(xf[0]);
        if (busy[0] && !busy_prev0) busy_edges0++;
        busy_prev0 = busy[0];
        busy_cnt2 += int'(busy[2]);
    endtask

    // Assert reset away from the clock edge; outputs must clear at once.
    task automatic apply_reset(input logic [2:0] b, input int cycles);
        btn = b;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_x[%0d]", i), x[i], 1'b0);
            check($sformatf("rst_rise[%0d]", i), xr[i], 1'b0);
            check($sformatf("rst_fall[%0d]", i), xf[i], 1'b0);
            check($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
        end
        model_clear();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        busy_prev0 = 1'b0;
    endtask

    task automatic seg_clear();
        rise_cnt0 = 0;
        fall_cnt0 = 0;
        busy_edges0 = 0;
    endtask

    initial begin
        int k0, k1, k2;
        busy_cnt2 = 0;
        busy_prev0 = 1'b0;
        seg_clear();
        #2;
        apply_reset(3'b000, 2);
        repeat (4) step(3'b000);

        // Clean press on all lanes.
        seg_clear();
        k0 = 0; k1 = 0; k2 = 0;
        for (int k = 1; k <= 14; k++) begin
            step(3'b111);
            if (x[0] && k0 == 0) k0 = k;
            if (x[1] && k1 == 0) k1 = k;
            if (x[2] && k2 == 0) k2 = k;
        end
        check_int("press_latency_st3", k0, 5);
        check_int("press_rises_st3", rise_cnt0, 1);
        check_int("press_latency_st1", k2, 3);
        n_cmp++;
        assert (k1 >= 6 && k1 <= 10) else begin
            n_err++;
            $error("FAIL press_window_div4 observed=%0d expected=6..10", k1);
        end

        // Clean release.
        seg_clear();
        k0 = 0;
        for (int k = 1; k <= 14; k++) begin
            step(3'b000);
            if (!x[0] && k0 == 0) k0 = k;
        end
        check_int("release_latency_st3", k0, 5);
        check_int("release_falls_st3", fall_cnt0, 1);

        // Bounce bursts narrower than the qualify window.
        seg_clear();
        repeat (4) begin
            step(3'b111); step(3'b111);
            step(3'b000); step(3'b000);
        end
        repeat (6) step(3'b000);
        check_int("bounce_rises_st3", rise_cnt0, 0);
        check_int("bounce_busy_pulses_st3", busy_edges0, 4);
        check("bounce_level_st3", x[0], 1'b0);

        // Bounce then settle high: edge k sees btn from step k-2.
        seg_clear();
        k0 = 0;
        for (int k = 1; k <= 12; k++) begin
            step((k == 2) ? 3'b000 : 3'b111);
            if (x[0] && k0 == 0) k0 = k;
        end
        check_int("settle_latency_st3", k0, 7);
        check_int("settle_rises_st3", rise_cnt0, 1);
        repeat (10) step(3'b000);

        // Reset mid-qualification with the button held high.
        repeat (3) step(3'b111);
        check("midqual_busy_st3", busy[0], 1'b1);
        apply_reset(3'b111, 2);
        seg_clear();
        k0 = 0;
        for (int k = 1; k <= 8; k++) begin
            step(3'b111);
            if (x[0] && k0 == 0) k0 = k;
            if (k == 5) check("post_reset_rise_e5", xr[0], 1'b1);
        end
        check_int("post_reset_latency_st3", k0, 5);
        check_int("post_reset_rises_st3", rise_cnt0, 1);
        check_int("st1_busy_never", busy_cnt2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
